// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Transmit half of the board UART. Bytes pushed by the host
//                are queued in a small FIFO and serialised as 8N1 frames,
//                LSB first, on tx. Line timing is 16x oversampled with DVSR
//                clk per tick, matching the companion receiver.
//  Ports       : clk        in   system clock, rising edge
//                reset_pin  in   synchronous reset, active-high
//                wr_tx_pin  in   active-low write strobe (one byte per clk)
//                w_data     in   byte pushed when wr_tx_pin is sampled 0
//                tx         out  serial line, idle high, registered
//                tx_full    out  FIFO full (registered)
//                tx_empty   out  FIFO empty (registered)
//                tx_busy    out  frame in progress (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 27,
    parameter int DVSR_W  = 5,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset_pin,
    input  logic            wr_tx_pin,
    input  logic [DBIT-1:0] w_data,
    output logic            tx,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy
);

    localparam int c_DEPTH = 2 ** FIFO_W;
    localparam int c_S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int c_N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [DBIT-1:0]   r_mem [0:c_DEPTH-1];
    logic [FIFO_W-1:0] r_wr_ptr;
    logic [FIFO_W-1:0] r_rd_ptr;
    logic [FIFO_W:0]   r_count;
    logic              r_full;
    logic              r_empty;

    // Transmitter state
    state_t            r_state;
    logic [c_S_W-1:0]  r_s;
    logic [c_N_W-1:0]  r_n;
    logic [DBIT-1:0]   r_b;
    logic [DVSR_W-1:0] r_baud;
    logic              r_tx;
    logic              r_busy;

    // Next-state values
    state_t            w_state_next;
    logic [c_S_W-1:0]  w_s_next;
    logic [c_N_W-1:0]  w_n_next;
    logic [DBIT-1:0]   w_b_next;
    logic              w_tx_next;
    logic              w_pop;
    logic              w_push;
    logic              w_tick;
    logic [FIFO_W:0]   w_count_next;

    // A push against a full FIFO is dropped even if the FSM pops this cycle.
    assign w_push = !wr_tx_pin && !r_full;
    assign w_tick = (r_baud == DVSR_W'(DVSR - 1));

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_b_next     = r_mem[r_rd_ptr];
                    w_s_next     = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == c_S_W'(15)) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == c_S_W'(15)) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == c_N_W'(DBIT - 1)) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == c_S_W'(SB_TICK - 1)) begin
                        // Chain straight into the next frame when data waits.
                        if (!r_empty) begin
                            w_pop        = 1'b1;
                            w_b_next     = r_mem[r_rd_ptr];
                            w_s_next     = '0;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // tx is registered from the state being entered, so the start bit
        // appears on the same edge that pops the byte.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_pin) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_b      <= '0;
            r_baud   <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            // Divider idles at 0 so every frame is timed from its own start edge.
            r_baud  <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (FIFO_W + 1)'(c_DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset_pin) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    assign tx       = r_tx;
    assign tx_full  = r_full;
    assign tx_empty = r_empty;
    assign tx_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A time-based model of
//                the serial line and byte queue is compared with the DUT on
//                every cycle; a bench-side serial decoder recovers the bytes
//                sent; directed literal checks pin key timing points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int BIT_CLK = 16 * 27;        // clk per bit
    localparam int FRAME   = 10 * BIT_CLK;   // start + 8 data + 1 stop
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_n;
    logic [7:0] data;
    logic       tx, tx_full, tx_empty, tx_busy;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_fifo dut (
        .clk       (clk),
        .reset_pin (rst),
        .wr_tx_pin (wr_n),
        .w_data    (data),
        .tx        (tx),
        .tx_full   (tx_full),
        .tx_empty  (tx_empty),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: byte queue plus elapsed time within the frame
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    bit         m_busy  = 0;
    bit         m_valid = 0;
    int         m_t     = 0;
    int         m_sz;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_busy  = 0;
            m_t     = 0;
            m_valid = 1;
        end else begin
            m_sz = mq.size();
            if (m_busy) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (m_sz != 0) begin
                        m_cur = mq.pop_front();
                        m_t   = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end else if (m_sz != 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1;
                m_t    = 0;
            end
            if (!wr_n && m_sz != DEPTH) mq.push_back(data);
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / BIT_CLK;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",       {31'd0, tx},       {31'd0, exp_tx()});
            chk("tx_busy",  {31'd0, tx_busy},  {31'd0, m_busy});
            chk("tx_full",  {31'd0, tx_full},  {31'd0, mq.size() == DEPTH});
            chk("tx_empty", {31'd0, tx_empty}, {31'd0, mq.size() == 0});
        end
    end

    // ------------------------------------------------------------------
    // Serial decoder: mid-bit sampling of tx
    // ------------------------------------------------------------------
    logic [7:0] rxq[$];
    logic [7:0] d_byte;
    bit         d_busy = 0;
    int         d_cnt  = 0;
    int         d_k;
    int         fe_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            d_busy = 0;
        end else if (!d_busy) begin
            if (tx === 1'b0) begin
                d_busy = 1;
                d_cnt  = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt % BIT_CLK == BIT_CLK / 2) begin
                d_k = d_cnt / BIT_CLK;
                if (d_k == 0) begin
                    if (tx !== 1'b0) fe_cnt++;
                end else if (d_k <= 8) begin
                    d_byte[d_k-1] = tx;
                end else begin
                    if (tx !== 1'b1) fe_cnt++;
                    rxq.push_back(d_byte);
                    d_busy = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [7:0] pushq[$];
    logic [7:0] expq[$];

    // Pushes pushq on consecutive edges; returns at the negedge after the last push edge.
    task automatic push_seq();
        for (int i = 0; i < pushq.size(); i++) begin
            @(negedge clk);
            wr_n = 1'b0;
            data = pushq[i];
        end
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((tx_busy !== 1'b0 || tx_empty !== 1'b1) && k < 30000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, k < 30000}, 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_rx();
        chk("rx_count", rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            chk("rx_byte", (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hDEAD, {24'd0, expq[i]});
        end
        chk("framing", fe_cnt, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        wr_n = 1'b1;
        data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx",    {31'd0, tx},       32'd1);
        chk("rst_full",  {31'd0, tx_full},  32'd0);
        chk("rst_empty", {31'd0, tx_empty}, 32'd1);
        chk("rst_busy",  {31'd0, tx_busy},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: single byte 0x55
        rxq.delete();
        pushq = '{8'h55};
        push_seq();                                         // after edge N
        chk("t1_pre_tx",    {31'd0, tx},       32'd1);
        chk("t1_pre_empty", {31'd0, tx_empty}, 32'd0);
        @(negedge clk);                                     // after N+1
        chk("t1_start",     {31'd0, tx},       32'd0);
        chk("t1_busy",      {31'd0, tx_busy},  32'd1);
        chk("t1_empty",     {31'd0, tx_empty}, 32'd1);
        repeat (BIT_CLK) @(negedge clk);                    // N+433: bit0
        chk("t1_bit0",      {31'd0, tx},       32'd1);
        repeat (BIT_CLK) @(negedge clk);                    // N+865: bit1
        chk("t1_bit1",      {31'd0, tx},       32'd0);
        repeat (FRAME - 865) @(negedge clk);                // N+4320
        chk("t1_stop_busy", {31'd0, tx_busy},  32'd1);
        chk("t1_stop_tx",   {31'd0, tx},       32'd1);
        @(negedge clk);                                     // N+4321
        chk("t1_done_busy", {31'd0, tx_busy},  32'd0);
        wait_idle();
        expq = '{8'h55};
        check_rx();

        // T2: back-to-back frames
        rxq.delete();
        pushq = '{8'hA3, 8'h3C, 8'hFF};
        push_seq();                                         // after N+2
        repeat (FRAME - 1) @(negedge clk);                  // N+4321
        chk("t2_b2b_tx",    {31'd0, tx},      32'd0);
        chk("t2_b2b_busy",  {31'd0, tx_busy}, 32'd1);
        repeat (2 * FRAME - 1) @(negedge clk);              // N+12960
        chk("t2_end_busy",  {31'd0, tx_busy}, 32'd1);
        @(negedge clk);                                     // N+12961
        chk("t2_idle_busy", {31'd0, tx_busy}, 32'd0);
        wait_idle();
        expq = '{8'hA3, 8'h3C, 8'hFF};
        check_rx();

        // T3 + T5: overflow, then push held across the STOP->START pop edge
        rxq.delete();
        pushq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_seq();                                         // after N+5
        chk("t3_full",      {31'd0, tx_full},  32'd1);
        chk("t3_empty",     {31'd0, tx_empty}, 32'd0);
        repeat (FRAME - 5) @(negedge clk);                  // N+4320
        chk("t3_full_hold", {31'd0, tx_full},  32'd1);
        wr_n = 1'b0;
        data = 8'h07;                                       // collides with pop: dropped
        @(negedge clk);                                     // N+4321
        chk("t5_collide",   {31'd0, tx_full},  32'd0);
        data = 8'h08;                                       // accepted
        @(negedge clk);                                     // N+4322
        chk("t5_refill",    {31'd0, tx_full},  32'd1);
        wr_n = 1'b1;
        wait_idle();
        expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08};
        check_rx();

        // T4: reset during data bit 3 with two bytes queued
        rxq.delete();
        pushq = '{8'hC3, 8'h11, 8'h22};
        push_seq();                                         // after N+2
        repeat (1898) @(negedge clk);                       // N+1900
        rst = 1'b1;
        @(negedge clk);                                     // N+1901
        rst = 1'b0;
        chk("t4_tx",    {31'd0, tx},       32'd1);
        chk("t4_empty", {31'd0, tx_empty}, 32'd1);
        chk("t4_busy",  {31'd0, tx_busy},  32'd0);
        chk("t4_full",  {31'd0, tx_full},  32'd0);
        repeat (3) @(negedge clk);
        pushq = '{8'h5A};
        push_seq();
        wait_idle();
        expq = '{8'h5A};
        check_rx();

        // T6: loopback-style recovery of a mixed byte set
        rxq.delete();
        pushq = '{8'h35, 8'h0D, 8'h00, 8'hFF};
        push_seq();
        wait_idle();
        expq = '{8'h35, 8'h0D, 8'h00, 8'hFF};
        check_rx();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
